// File: rtl/uart_send_2480_pkg.sv
// Shared types and helpers for the 2480 UART transmit/receive pair.
// Optional feature macro used by this block: UART_TX_PARITY_EN.
package uart_2480_pkg;

    localparam int TX_CNT_W  = 4;
    localparam int CLK_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_send_2480_if.sv
// Host-side request/status bundle of the UART transmitter.
// The host drives through the master modport; the transmitter uses the slave modport.
interface uart_send_2480_if;
    import uart_2480_pkg::*;

    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_ready;
    logic                tx_done;
    logic [TX_CNT_W-1:0] tx_cnt;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx_done,
        input  tx_cnt
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx_done,
        output tx_cnt
    );

endinterface

// File: rtl/uart_send_2480_baud_gen.sv
// Bit-period timer shared by the UART transmit and receive paths.
// Counts 0..BPS_CNT-1 while enabled and pulses bit_end on the last count.
module uart_baud_gen_2480
    import uart_2480_pkg::*;
#(
    parameter int BPS_CNT = 5120
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam logic [CLK_CNT_W-1:0] LAST = CLK_CNT_W'(BPS_CNT - 1);

    logic [CLK_CNT_W-1:0] clk_cnt;

    assign bit_end = enable && (clk_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            clk_cnt <= '0;
        end else if (bit_end) begin
            clk_cnt <= '0;
        end else if (enable) begin
            clk_cnt <= clk_cnt + CLK_CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_send_2480.sv
// UART transmitter, 8N1 LSB first; define UART_TX_PARITY_EN to insert an even-parity bit.
// All outputs are registered; a new request is accepted in the tx_done cycle.
module uart_send_2480
    import uart_2480_pkg::*;
#(
    parameter int CLK_FREQ = 49152000,
    parameter int UART_BPS = 9600
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    uart_send_2480_if.slave  bus,
    output logic             uart_txd
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);

    generate
        if (BPS_CNT > 65535 || BPS_CNT < 2) begin : g_bps_check
            $error("uart_send_2480: BPS_CNT out of range");
        end
    endgenerate

    tx_state_t           state, state_next;
    logic [TX_CNT_W-1:0] cnt_q, cnt_next;
    logic [7:0]          shift_q, shift_next;
    logic                txd_q, txd_next;
    logic                ready_q, ready_next;
    logic                done_q, done_next;
    logic                accept;
    logic                bit_end;
`ifdef UART_TX_PARITY_EN
    logic [7:0]          latched_q, latched_next;
`endif

    assign accept = ready_q && bus.tx_start;

    uart_baud_gen_2480 #(.BPS_CNT(BPS_CNT)) u_baud (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clear   (accept),
        .enable  (state != IDLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            latched_q <= '0;
`endif
        end else begin
            state     <= state_next;
            cnt_q     <= cnt_next;
            shift_q   <= shift_next;
            txd_q     <= txd_next;
            ready_q   <= ready_next;
            done_q    <= done_next;
`ifdef UART_TX_PARITY_EN
            latched_q <= latched_next;
`endif
        end
    end

    // Each bit boundary loads the next line level, so uart_txd changes exactly with tx_cnt.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt_q;
        shift_next   = shift_q;
        txd_next     = txd_q;
        ready_next   = ready_q;
        done_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
        latched_next = latched_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = START;
                    shift_next   = bus.tx_data;
                    txd_next     = 1'b0;
                    ready_next   = 1'b0;
                    cnt_next     = '0;
`ifdef UART_TX_PARITY_EN
                    latched_next = bus.tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    cnt_next   = cnt_q + TX_CNT_W'(1);
                    txd_next   = shift_q[0];
                    shift_next = {1'b0, shift_q[7:1]};
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_next = cnt_q + TX_CNT_W'(1);
                    if (cnt_q == TX_CNT_W'(8)) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        txd_next   = ^latched_q;
`else
                        state_next = STOP;
                        txd_next   = 1'b1;
`endif
                    end else begin
                        txd_next   = shift_q[0];
                        shift_next = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    cnt_next   = cnt_q + TX_CNT_W'(1);
                    txd_next   = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    txd_next   = 1'b1;
                    ready_next = 1'b1;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                txd_next   = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end

    assign uart_txd     = txd_q;
    assign bus.tx_ready = ready_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_cnt   = cnt_q;

endmodule
